// File: rtl/neuron_backprop.sv
// Backward pass for a 7-input neuron: delta = e*y*(1-y), weight update and back-propagated error,
// sequenced through one shared 17x17 multiplier. Define NEURON_BP_SAT_EN to saturate, else wrap.
module neuron_backprop #(
    parameter int unsigned OUTPUT_LAYER = 1,
    parameter int unsigned N_IN         = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [17*N_IN-1:0]   x,
    input  logic [17*N_IN-1:0]   w,
    input  logic [16:0]          y,
    input  logic [16:0]          target,
    input  logic [16:0]          err_in,
    input  logic [16:0]          eta,
    output logic                 busy,
    output logic                 done,
    output logic [16:0]          delta,
    output logic [17*N_IN-1:0]   w_new,
    output logic [17*N_IN-1:0]   back_err
);

    localparam int unsigned W = 17;

    typedef enum logic [2:0] {
        StIdle, StErr, StDeriv, StDelta, StScale, StUpd, StBack, StDone
    } state_e;

    state_e state_q, state_d;
    logic [2:0] idx_q, idx_d;

    logic [W*N_IN-1:0] x_q, w_q;
    logic [15:0]       y_q;
    logic [W-1:0]      src_q, eta_q, e_q, d_q, delta_q, g_q;
    logic [W*N_IN-1:0] w_new_q, back_err_q;

    logic [W-1:0] x_sel, w_sel;
    logic signed [W-1:0]     mul_a, mul_b;
    logic signed [2*W-1:0]   p;
    logic [W:0]   sub, sum;
    logic [W-1:0] mul_r, sub_r, sum_r, e_val;
    logic         accept;

    assign accept = (state_q == StIdle) && start;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle:  if (start) begin
                state_d = StErr;
                idx_d   = '0;
            end
            StErr:   state_d = StDeriv;
            StDeriv: state_d = StDelta;
            StDelta: state_d = StScale;
            StScale: state_d = StUpd;
            StUpd:   state_d = StBack;
            StBack:  if (idx_q == 3'(N_IN - 1)) begin
                state_d = StDone;
            end else begin
                state_d = StUpd;
                idx_d   = idx_q + 3'd1;
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        x_sel = x_q[W*idx_q +: W];
        w_sel = w_q[W*idx_q +: W];
    end

    // Operand mux for the single shared multiplier. In StDeriv, y=0 gives b=-65536, product still 0.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        unique case (state_q)
            StDeriv: begin
                mul_a = {1'b0, y_q};
                mul_b = 17'h10000 - {1'b0, y_q};
            end
            StDelta: begin
                mul_a = e_q;
                mul_b = d_q;
            end
            StScale: begin
                mul_a = eta_q;
                mul_b = delta_q;
            end
            StUpd: begin
                mul_a = g_q;
                mul_b = x_sel;
            end
            StBack: begin
                mul_a = w_sel;
                mul_b = delta_q;
            end
            default: ;
        endcase
    end

    assign p   = $signed({{W{mul_a[W-1]}}, mul_a}) * $signed({{W{mul_b[W-1]}}, mul_b});
    assign sub = {src_q[W-1], src_q} - {2'b00, y_q};
    assign sum = {w_sel[W-1], w_sel} + {mul_r[W-1], mul_r};

`ifdef NEURON_BP_SAT_EN
    function automatic logic [W-1:0] sat17(input logic [W:0] s);
        if (s[W] != s[W-1]) begin
            return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        return s[W-1:0];
    endfunction

    assign mul_r = (p[2*W-1] != p[2*W-2]) ? (p[2*W-1] ? {1'b1, {(W-1){1'b0}}}
                                                       : {1'b0, {(W-1){1'b1}}})
                                          : p[2*W-2:W-1];
    assign sub_r = sat17(sub);
    assign sum_r = sat17(sum);

    logic unused_p_lsbs;
    assign unused_p_lsbs = ^p[W-2:0];
`else
    assign mul_r = p[2*W-2:W-1];
    assign sub_r = sub[W-1:0];
    assign sum_r = sum[W-1:0];

    logic unused_msbs;
    assign unused_msbs = ^{p[2*W-1], p[W-2:0], sub[W], sum[W]};
`endif

    assign e_val = (OUTPUT_LAYER != 0) ? sub_r : src_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            idx_q      <= '0;
            x_q        <= '0;
            w_q        <= '0;
            y_q        <= '0;
            src_q      <= '0;
            eta_q      <= '0;
            e_q        <= '0;
            d_q        <= '0;
            delta_q    <= '0;
            g_q        <= '0;
            w_new_q    <= '0;
            back_err_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (accept) begin
                x_q   <= x;
                w_q   <= w;
                // Out-of-range activations clamp to just below 1.0
                y_q   <= y[16] ? 16'hFFFF : y[15:0];
                src_q <= (OUTPUT_LAYER != 0) ? target : err_in;
                eta_q <= eta;
            end
            case (state_q)
                StErr:   e_q     <= e_val;
                StDeriv: d_q     <= mul_r;
                StDelta: delta_q <= mul_r;
                StScale: g_q     <= mul_r;
                StUpd:   w_new_q[W*idx_q +: W]    <= sum_r;
                StBack:  back_err_q[W*idx_q +: W] <= mul_r;
                default: ;
            endcase
        end
    end

    assign busy     = (state_q != StIdle) && (state_q != StDone);
    assign done     = (state_q == StDone);
    assign delta    = delta_q;
    assign w_new    = w_new_q;
    assign back_err = back_err_q;

endmodule
